// File: rtl/input_conditioner.sv
// Front-panel input conditioner: synchronises WIDTH asynchronous inputs, debounces
// each bit on a divided sample tick, and produces levels, edge pulses and sticky events.
module input_conditioner #(
  parameter int WIDTH       = 8,
  parameter int TICK_DIV    = 100000,
  parameter int STABLE_CNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  output logic             any_evt,
  output logic             tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             tick_next;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] evt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // tick is registered from the next divider value so it lines up with div_cnt == TICK_DIV-1
  always_comb begin
    div_next  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    tick_next = (div_next == DIV_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      tick    <= tick_next;
    end
  end

  always_comb begin
    dout_d = dout;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i];
    if (tick) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] == dout[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          dout_d[i] = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // a rise in the same cycle overrides a clear request
    evt_d = (evt & ~evt_clr) | rise_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      dout    <= '0;
      rise    <= '0;
      fall    <= '0;
      evt     <= '0;
      any_evt <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
      evt     <= evt_d;
      any_evt <= |evt_d;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (WIDTH=4, TICK_DIV=4, STABLE_CNT=3).
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic [3:0] evt_clr;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] evt;
  logic       any_evt;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  input_conditioner #(
    .WIDTH      (4),
    .TICK_DIV   (4),
    .STABLE_CNT (3),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .evt_clr(evt_clr),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .evt    (evt),
    .any_evt(any_evt),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_dout(input int idx, input logic val, input int limit, output int n);
    n = 0;
    while (dout[idx] !== val && n < limit) begin
      step();
      n++;
    end
  endtask

  int n;
  int bad;
  int ticks;

  initial begin
    reset   = 1'b0;
    din     = 4'hF;
    evt_clr = 4'h0;
    repeat (3) step();
    check_eq("rst_dout", dout, 0);
    check_eq("rst_pulses", {rise, fall}, 0);
    check_eq("rst_evt", {evt, any_evt}, 0);
    check_eq("rst_tick", tick, 0);

    // Release with inputs idle: 100 quiet clocks, tick on every 4th
    reset = 1'b1;
    din   = 4'h0;
    cyc   = 0;
    bad   = 0;
    ticks = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (dout !== 0 || rise !== 0 || fall !== 0 || evt !== 0 || any_evt !== 0) bad++;
      if (tick !== ((cyc % 4) == 3)) bad++;
      if (tick === 1'b1) ticks++;
    end
    check_eq("idle_quiet", bad, 0);
    check_eq("idle_ticks", ticks, 25);

    // Clean press on bit 0 at cyc 100: samples at 104/108/112
    din[0] = 1'b1;
    wait_dout(0, 1'b1, 40, n);
    check_eq("press_latency", n, 12);
    check_eq("press_rise", rise, 4'b0001);
    check_eq("press_fall", fall, 0);
    check_eq("press_evt", {evt, any_evt}, {4'b0001, 1'b1});
    step();
    check_eq("press_rise_end", rise, 0);
    check_eq("press_evt_hold", evt, 4'b0001);

    // Bounce on bit 1, tick-aligned toggling for 64 clks
    while ((cyc % 4) != 0) step();
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      din[1] = ~j[0];
      repeat (4) begin
        step();
        if (dout[1] !== 1'b0 || rise[1] !== 1'b0 || evt[1] !== 1'b0) bad++;
      end
    end
    check_eq("bounce_reject", bad, 0);
    din[1] = 1'b1;
    wait_dout(1, 1'b1, 40, n);
    check_eq("bounce_settle", n, 12);
    check_eq("bounce_rise", rise, 4'b0010);
    check_eq("bounce_evt", evt, 4'b0011);

    // Release bit 0, then clear events one bit at a time
    din[0] = 1'b0;
    wait_dout(0, 1'b0, 40, n);
    check_eq("release_latency", n, 12);
    check_eq("release_fall", fall, 4'b0001);
    check_eq("release_rise", rise, 0);
    check_eq("release_evt", evt, 4'b0011);
    step();
    check_eq("release_fall_end", fall, 0);
    evt_clr = 4'b0001;
    step();
    evt_clr = 4'b0000;
    check_eq("clr0_evt", {evt, any_evt}, {4'b0010, 1'b1});
    evt_clr = 4'b0010;
    step();
    evt_clr = 4'b0000;
    check_eq("clr1_evt", {evt, any_evt}, {4'b0000, 1'b0});

    // Bits 2 and 3 together; clear bit 2 on the edge that raises it (cyc 220)
    din = 4'b1110;
    repeat (12) step();
    check_eq("pair_pending", {dout, rise}, {4'b0010, 4'b0000});
    evt_clr = 4'b0100;
    step();
    evt_clr = 4'b0000;
    check_eq("pair_rise", rise, 4'b1100);
    check_eq("pair_dout", dout, 4'b1110);
    check_eq("collide_evt", {evt, any_evt}, {4'b1100, 1'b1});
    step();
    check_eq("collide_hold", {evt, rise}, {4'b1100, 4'b0000});

    // Drop bits 2/3 at cyc 221: samples 224/228/232
    din = 4'b0010;
    repeat (11) step();
    check_eq("pair_fall", {dout, fall}, {4'b0010, 4'b1100});

    // Bit 3 qualifies twice (240 leaves count at 2), then async reset mid-cycle
    din = 4'b1010;
    repeat (9) step();
    check_eq("pre_reset_dout", dout, 4'b0010);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_dout", dout, 0);
    check_eq("async_evt", {evt, any_evt}, 0);
    check_eq("async_pulses", {rise, fall, tick}, 0);
    step();
    check_eq("held_reset", {dout, evt, rise, fall, any_evt, tick}, 0);
    reset = 1'b1;
    cyc   = 0;
    wait_dout(3, 1'b1, 40, n);
    check_eq("requalify_latency", n, 12);
    check_eq("requalify_rise", rise, 4'b1010);
    check_eq("requalify_evt", {evt, any_evt}, {4'b1010, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
